// File: rtl/strobe_generator.sv
// -----------------------------------------------------------------------------
// strobe_generator
//
// Free-running periodic strobe source. While Enable_i is high, Strobe_o pulses
// high for exactly one clock once every PERIOD_NS nanoseconds. The period is
// rounded to a whole number of clock ticks when the design is elaborated.
// Typical uses are UART baud ticks, debounce sampling and display refresh.
//
// Parameters:
//   CLOCK_HZ   input clock frequency in Hz (must be > 0)
//   PERIOD_NS  requested strobe period in ns (must round to >= 1 clock tick)
//
// Derived localparams (readable hierarchically):
//   CLOCK_PERIOD_NS  clock period in ns (real)
//   TICKS            strobe period in clock ticks, rounded to nearest
//   REAL_PERIOD_NS   period actually produced, TICKS * CLOCK_PERIOD_NS (real)
//   WIDTH            tick counter width, max(1, clog2(TICKS))
//
// Ports:
//   Clock     in   system clock, rising edge
//   Reset     in   asynchronous active-high reset
//   Enable_i  in   run enable, synchronous to Clock
//   Strobe_o  out  registered one-clock strobe
// -----------------------------------------------------------------------------
module strobe_generator #(
    parameter int CLOCK_HZ  = 10_000_000,
    parameter int PERIOD_NS = 1000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Enable_i,
    output logic Strobe_o
);

    // The guard keeps elaboration from dividing by zero; the fatal check
    // below reports the bad parameter instead.
    localparam real CLOCK_PERIOD_NS = (CLOCK_HZ > 0) ? (1.0e9 / real'(CLOCK_HZ)) : 1.0;

    // Explicit floor(x + 0.5) so the rounding does not depend on how a tool
    // converts real to integer.
    localparam int  TICKS          = int'($floor(real'(PERIOD_NS) / CLOCK_PERIOD_NS + 0.5));
    localparam real REAL_PERIOD_NS = real'(TICKS) * CLOCK_PERIOD_NS;
    localparam int  WIDTH          = (TICKS > 1) ? $clog2(TICKS) : 1;

    // Terminal count; only meaningful once the checks below have passed.
    localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(TICKS - 1);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    generate
        if (CLOCK_HZ <= 0) begin : g_bad_clock_hz
            $fatal(1, "strobe_generator: CLOCK_HZ must be positive");
        end
        if ((TICKS < 1) || (REAL_PERIOD_NS <= 0.0)) begin : g_bad_period
            $fatal(1, "strobe_generator: PERIOD_NS is shorter than half a clock period");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Tick counter and strobe register
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             strobe_q;
    logic             strobe_d;

    // Disabled: the partial count is discarded so a re-enable always waits a
    // full period. Enabled: count up to LAST_COUNT, then wrap to 0 while
    // firing the strobe. The counter starts at 0 and only ever steps by one
    // up to LAST_COUNT, so codes above it are never reached.
    always_comb begin
        count_d  = '0;
        strobe_d = 1'b0;
        if (Enable_i) begin
            if (count_q == LAST_COUNT) begin
                count_d  = '0;
                strobe_d = 1'b1;
            end else begin
                count_d  = count_q + WIDTH'(1);
                strobe_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            strobe_q <= strobe_d;
        end
    end

    // Output comes straight from the flip-flop, so it cannot glitch.
    assign Strobe_o = strobe_q;

endmodule

// File: tb/tb_strobe_generator.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_strobe_generator
//
// Four instances share clock, reset and enable: the defaults (1000 ns), the
// rounding cases 1049 ns and 1051 ns, and the single-tick case 100 ns, all at
// 10 MHz. The reference model counts consecutive edges that sampled Enable_i
// high with Reset low; an instance with period T must strobe after exactly
// those edges where that run length is a non-zero multiple of T.
// -----------------------------------------------------------------------------
module tb_strobe_generator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic s_def;
    logic s_1049;
    logic s_1051;
    logic s_100;

    always #50 clk = ~clk;   // 10 MHz

    strobe_generator u_def (
        .Clock(clk), .Reset(rst), .Enable_i(en), .Strobe_o(s_def)
    );
    strobe_generator #(.CLOCK_HZ(10_000_000), .PERIOD_NS(1049)) u_1049 (
        .Clock(clk), .Reset(rst), .Enable_i(en), .Strobe_o(s_1049)
    );
    strobe_generator #(.CLOCK_HZ(10_000_000), .PERIOD_NS(1051)) u_1051 (
        .Clock(clk), .Reset(rst), .Enable_i(en), .Strobe_o(s_1051)
    );
    strobe_generator #(.CLOCK_HZ(10_000_000), .PERIOD_NS(100)) u_100 (
        .Clock(clk), .Reset(rst), .Enable_i(en), .Strobe_o(s_100)
    );

    // Period in ticks, rounded to nearest, using integer arithmetic only.
    function automatic int model_ticks(input longint hz, input longint pns);
        return int'((pns * hz + 64'd500_000_000) / 64'd1_000_000_000);
    endfunction

    localparam int T_DEF  = model_ticks(10_000_000, 1000);
    localparam int T_1049 = model_ticks(10_000_000, 1049);
    localparam int T_1051 = model_ticks(10_000_000, 1051);
    localparam int T_100  = model_ticks(10_000_000, 100);

    // Reference model: length of the current run of enabled, unreset edges.
    int run = 0;
    always @(posedge clk or posedge rst) begin
        if (rst)     run <= 0;
        else if (en) run <= run + 1;
        else         run <= 0;
    end

    function automatic logic exp_strobe(input int r, input int t);
        return (r != 0) && ((r % t) == 0);
    endfunction

    int errors = 0;
    int checks = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_real(input string name, input real act, input real exp);
        checks++;
        if ((act - exp > 1.0e-6) || (exp - act > 1.0e-6)) begin
            errors++;
            $display("FAIL %s: got %f, expected %f at %0t", name, act, exp, $time);
        end
    endtask

    // Strobe rise times (ns) for spacing checks, captured at the sampling edge.
    real  rises_def[$];
    real  rises_1051[$];
    logic prev_def  = 1'b0;
    logic prev_1051 = 1'b0;

    // Advance one clock and compare every instance against the model at the
    // falling edge, away from the active edge.
    task automatic step();
        @(negedge clk);
        check_bit("cmp_def",  s_def,  exp_strobe(run, T_DEF));
        check_bit("cmp_1049", s_1049, exp_strobe(run, T_1049));
        check_bit("cmp_1051", s_1051, exp_strobe(run, T_1051));
        check_bit("cmp_100",  s_100,  exp_strobe(run, T_100));
        if (s_def && !prev_def)   rises_def.push_back($realtime);
        if (s_1051 && !prev_1051) rises_1051.push_back($realtime);
        prev_def  = s_def;
        prev_1051 = s_1051;
    endtask

    initial begin
        int first;
        int hi;
        int n;

        // ---------------- reset state ----------------
        repeat (3) step();
        check_bit("reset_state_def", s_def, 1'b0);
        check_bit("reset_state_100", s_100, 1'b0);
        rst = 1'b0;
        repeat (2) step();

        // ---------------- derived constants ----------------
        check_int ("TICKS_def",           u_def.TICKS, 10);
        check_int ("WIDTH_def",           u_def.WIDTH, 4);
        check_real("CLOCK_PERIOD_NS_def", u_def.CLOCK_PERIOD_NS, 100.0);
        check_real("REAL_PERIOD_NS_def",  u_def.REAL_PERIOD_NS, 1000.0);
        check_int ("TICKS_1049",          u_1049.TICKS, 10);
        check_real("REAL_PERIOD_NS_1049", u_1049.REAL_PERIOD_NS, 1000.0);
        check_int ("TICKS_1051",          u_1051.TICKS, 11);
        check_int ("TICKS_100",           u_100.TICKS, 1);
        check_int ("WIDTH_100",           u_100.WIDTH, 1);
        $display("constants: def TICKS=%0d WIDTH=%0d, 1051 TICKS=%0d", u_def.TICKS, u_def.WIDTH, u_1051.TICKS);

        // ---------------- first strobe and spacing ----------------
        rises_def.delete();
        rises_1051.delete();
        en    = 1'b1;
        first = 0;
        hi    = 0;
        for (int i = 1; i <= 45; i++) begin
            step();
            if (s_def && first == 0) first = i;
            if (s_def) hi++;
        end
        check_int("first_strobe_edge", first, 10);
        check_int("strobe_count_def", rises_def.size(), 4);
        check_int("high_cycles_def", hi, 4);
        for (int i = 1; i < rises_def.size(); i++)
            check_real("spacing_def", rises_def[i] - rises_def[i-1], 1000.0);
        check_int("strobe_count_1051", rises_1051.size(), 4);
        for (int i = 1; i < rises_1051.size(); i++)
            check_real("spacing_1051", rises_1051[i] - rises_1051[i-1], 1100.0);
        $display("periodic: first strobe at edge %0d, %0d strobes", first, rises_def.size());

        // ---------------- reset held with enable high ----------------
        rst = 1'b1;
        hi  = 0;
        repeat (30) begin
            step();
            if (s_def || s_1049 || s_1051 || s_100) hi++;
        end
        check_int("strobes_in_reset", hi, 0);
        rst = 1'b0;
        $display("reset hold: %0d strobes during 30 reset clocks", hi);

        // ---------------- async reset during a strobe ----------------
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (s_def) begin
                n = i;
                break;
            end
        end
        check_int("strobe_before_async_reset", n, 10);
        #5  rst = 1'b1;
        #1  check_bit("async_drop_def", s_def, 1'b0);
        check_bit("async_drop_100", s_100, 1'b0);
        #5  rst = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (s_def) begin
                n = i;
                break;
            end
        end
        check_int("strobe_after_reset", n, 10);
        $display("async reset: next strobe %0d edges after release", n);

        // ---------------- enable gap at count 5 ----------------
        en = 1'b0;
        step();
        en = 1'b1;
        repeat (5) step();
        en = 1'b0;
        hi = 0;
        repeat (3) begin
            step();
            if (s_def || s_1049 || s_1051 || s_100) hi++;
        end
        check_int("strobes_in_gap", hi, 0);
        en = 1'b1;
        n  = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (s_def) begin
                n = i;
                break;
            end
        end
        check_int("strobe_after_reenable", n, 10);
        $display("enable gap: next strobe %0d edges after re-enable", n);

        // ---------------- enable drops when strobe is due ----------------
        en = 1'b0;
        step();
        en = 1'b1;
        repeat (9) step();
        en = 1'b0;
        step();
        check_bit("no_strobe_when_disabled", s_def, 1'b0);
        $display("drop on due cycle: strobe=%b", s_def);

        // ---------------- single-tick continuous strobe ----------------
        step();
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_bit("tick1_continuous", s_100, 1'b1);
        end
        $display("single tick: strobe=%b while enabled", s_100);

        // ---------------- randomized run ----------------
        for (int i = 0; i < 3000; i++) begin
            step();
            en = ($urandom_range(0, 99) < 92);
            if (rst) begin
                if ($urandom_range(0, 99) < 40) rst = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                // Short reset pulse entirely between edges.
                #7 rst = 1'b1;
                #1 check_bit("rand_async_drop", s_def | s_1049 | s_1051 | s_100, 1'b0);
                #5 rst = 1'b0;
            end
        end
        $display("random: %0d cycles done", 3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/strobe_generator.md
Name: strobe_generator

Overview:
- Free-running periodic strobe source: emits a one-clock-wide pulse on Strobe_o every PERIOD_NS nanoseconds while Enable_i is high.
- The period is converted at elaboration time to an integer number of clock ticks.
- Used as a timebase tick for slower logic, for example UART baud ticks, debounce sampling or display refresh.
- The derived constants are exposed as localparams so benches can read them hierarchically.

Parameters:
- CLOCK_HZ, default 10_000_000: input clock frequency in Hz, integer.
- PERIOD_NS, default 1000: requested strobe period in ns, integer.
- Derived localparams, not overridable:
  - CLOCK_PERIOD_NS (real) = 1e9 / CLOCK_HZ.
  - TICKS (integer) = round(PERIOD_NS / CLOCK_PERIOD_NS). With the defaults this is 10.
  - REAL_PERIOD_NS (real) = TICKS * CLOCK_PERIOD_NS. With the defaults this is 1000.0.
  - WIDTH = max(1, clog2(TICKS)). With the defaults this is 4.

Ports:
- Clock, input, 1: system clock. All logic is on the rising edge.
- Reset, input, 1: asynchronous, active-high reset.
- Enable_i, input, 1: synchronous run enable.
- Strobe_o, output, 1: registered strobe, high for exactly one Clock period per strobe period.

Behaviour:
- Elaboration checks:
  - If TICKS < 1, meaning PERIOD_NS is shorter than half a clock period, raise a fatal elaboration error.
  - Also raise a fatal error if CLOCK_HZ <= 0.
- Reset:
  - While Reset = 1: counter = 0 and Strobe_o = 0, immediately and independent of Clock.
  - Reset takes priority over everything else.
  - Deassertion is sampled on the next rising edge.
- State: one counter register, WIDTH bits wide, range 0..TICKS-1, plus one Strobe_o register.
- Each rising edge with Reset = 0 and Enable_i = 0:
  - counter <= 0 and Strobe_o <= 0.
  - Disabling mid-period discards the partial count.
- Each rising edge with Reset = 0 and Enable_i = 1:
  - If counter == TICKS-1: counter <= 0 and Strobe_o <= 1.
  - Otherwise: counter <= counter + 1 and Strobe_o <= 0.
- First-strobe latency: let edge k be the first rising edge that samples Enable_i = 1. Strobe_o rises just after edge k+TICKS-1 and stays high for one clock.
- Subsequent strobes repeat every TICKS clocks, for as long as Enable_i stays high.
- Wrap-around: the counter must never exceed TICKS-1. When TICKS is not a power of two, the unused codes must not be reachable.
- TICKS = 1: Strobe_o is high on every cycle in which the previous edge sampled Enable_i = 1, so it reads as continuously high while enabled.
- Enable_i dropping on the cycle a strobe is due: no strobe is produced. Strobe_o is 0 after that edge.
- Reset asserted mid-period or during a strobe: Strobe_o drops to 0 asynchronously. After release, counting restarts from 0.
- No glitches: Strobe_o is driven directly from a flip-flop.
- Enable_i is assumed synchronous to Clock. Synchronizing an asynchronous enable is the caller's responsibility.

Test Plan:
- Defaults, 10 MHz clock and 1000 ns period, stimulus: after reset is released, raise Enable_i at one rising edge.
  - Four consecutive Strobe_o rising edges exactly 1000 ns apart, each high for 100 ns.
  - The first strobe rises 10 clock edges after the first edge that samples Enable_i high.
  - Hierarchical reads give TICKS = 10, WIDTH = 4, CLOCK_PERIOD_NS = 100.0 and REAL_PERIOD_NS = 1000.0.
- Reset held high with Enable_i = 1 for 30 clocks: Strobe_o stays 0 throughout.
- Reset asserted between clock edges while Strobe_o = 1: Strobe_o goes to 0 before the next edge.
- After reset is released, the next strobe arrives 10 enabled edges later.
- Enable_i dropped for 3 clocks at counter value 5, then raised again:
  - No strobe occurs during the gap.
  - The next strobe comes a full 10 enabled edges after re-enable, not 5.
- Rounding case, PERIOD_NS = 1049 at 10 MHz: TICKS = 10, REAL_PERIOD_NS = 1000.0.
- PERIOD_NS = 1051 at 10 MHz: TICKS = 11, strobe spacing 1100 ns.
- Single-tick case, PERIOD_NS = 100: TICKS = 1, WIDTH = 1, and Strobe_o is high on every cycle after the first enabled edge.
